// File: rtl/dual_port_mem_pkg.sv
// Shared sizes, op encoding and port FSM state type for the dual-port memory.
package dual_port_mem_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 2 ** ADDR_W;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } port_state_e;

endpackage

// File: rtl/dual_port_mem_port.sv
// One request port: IDLE/RESP FSM with registered ready strobe and read data.
// Handshake: a request is taken at an edge where valid=1 in IDLE; ready is high
// for the following cycle only, and nothing is taken while in RESP.
module dual_port_mem_port #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              valid,
  input  logic              op,
  input  logic [DATA_W-1:0] mem_word,
  output logic              accept,
  output logic              ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              state_dbg
);
  import dual_port_mem_pkg::*;

  port_state_e state;

  assign accept    = (state == IDLE) && valid;
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      ready   <= 1'b0;
      rd_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          ready <= 1'b0;
          if (valid) begin
            state <= RESP;
            ready <= 1'b1;
            // mem_word is the pre-edge content, so a same-edge write on the
            // other port is not visible to this read.
            if (op == OP_READ) begin
              rd_data <= mem_word;
            end
          end
        end
        RESP: begin
          state <= IDLE;
          ready <= 1'b0;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/dual_port_mem.sv
// Dual-port memory: one shared array, two identical request ports, port A wins
// when both write the same word at the same edge.
module dual_port_mem #(
  parameter int DATA_W = dual_port_mem_pkg::DATA_W,
  parameter int ADDR_W = dual_port_mem_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              valid_a,
  input  logic              op_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] wr_data_a,
  output logic              ready_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic              valid_b,
  input  logic              op_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wr_data_b,
  output logic              ready_b,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              state_a,
  output logic              state_b
);
  import dual_port_mem_pkg::*;

  localparam int MEM_DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [MEM_DEPTH];
  logic              accept_a;
  logic              accept_b;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem[i[ADDR_W-1:0]] <= '0;
      end
    end else begin
      // B is scheduled first so that A's assignment overrides it on a collision.
      if (accept_b && (op_b == OP_WRITE)) begin
        mem[addr_b] <= wr_data_b;
      end
      if (accept_a && (op_a == OP_WRITE)) begin
        mem[addr_a] <= wr_data_a;
      end
    end
  end

  dual_port_mem_port #(.DATA_W(DATA_W)) u_port_a (
    .clk      (clk),
    .rstn     (rstn),
    .valid    (valid_a),
    .op       (op_a),
    .mem_word (mem[addr_a]),
    .accept   (accept_a),
    .ready    (ready_a),
    .rd_data  (rd_data_a),
    .state_dbg(state_a)
  );

  dual_port_mem_port #(.DATA_W(DATA_W)) u_port_b (
    .clk      (clk),
    .rstn     (rstn),
    .valid    (valid_b),
    .op       (op_b),
    .mem_word (mem[addr_b]),
    .accept   (accept_b),
    .ready    (ready_b),
    .rd_data  (rd_data_b),
    .state_dbg(state_b)
  );

endmodule

// File: tb/tb_dual_port_mem.sv
// Self-checking bench for dual_port_mem: reference memory model plus per-port
// expected-read queues, one task per scenario.
interface dut_if #(parameter int DW = 32, parameter int AW = 8);
  logic [DW-1:0] data;
  logic [AW-1:0] addr;
  logic          we;
  logic          valid;
  logic          ready;
  logic [DW-1:0] q;
endinterface

module tb_dual_port_mem;
  localparam int DW = 32;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic state_a;
  logic state_b;

  dut_if #(.DW(DW), .AW(AW)) a_if ();
  dut_if #(.DW(DW), .AW(AW)) b_if ();

  dual_port_mem #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .valid_a  (a_if.valid),
    .op_a     (a_if.we),
    .addr_a   (a_if.addr),
    .wr_data_a(a_if.data),
    .ready_a  (a_if.ready),
    .rd_data_a(a_if.q),
    .valid_b  (b_if.valid),
    .op_b     (b_if.we),
    .addr_b   (b_if.addr),
    .wr_data_b(b_if.data),
    .ready_b  (b_if.ready),
    .rd_data_b(b_if.q),
    .state_a  (state_a),
    .state_b  (state_b)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] model [256];
  logic [DW-1:0] exp_qa [$];
  logic [DW-1:0] exp_qb [$];
  logic [DW-1:0] last_a;
  logic [DW-1:0] last_b;

  task automatic model_reset();
    for (int i = 0; i < 256; i++) model[i] = '0;
    last_a = '0;
    last_b = '0;
    exp_qa.delete();
    exp_qb.delete();
  endtask

  // Drive one request pair, score both ports at ready, then idle one cycle.
  // Called at a point between edges; returns 1 time unit after a posedge.
  task automatic xact(input logic va, input logic oa, input logic [AW-1:0] aa,
                      input logic [DW-1:0] da, input logic vb, input logic ob,
                      input logic [AW-1:0] ab, input logic [DW-1:0] db,
                      input string tag);
    logic [DW-1:0] e;
    a_if.valid = va; a_if.we = oa; a_if.addr = aa; a_if.data = da;
    b_if.valid = vb; b_if.we = ob; b_if.addr = ab; b_if.data = db;
    if (va && !oa) exp_qa.push_back(model[aa]);
    if (vb && !ob) exp_qb.push_back(model[ab]);
    if (vb && ob) model[ab] = db;
    if (va && oa) model[aa] = da;
    @(posedge clk); #1;
    vectors++;
    if (a_if.ready !== va) begin
      miscompares++;
      $display("FAIL %s ready_a: got %b expected %b", tag, a_if.ready, va);
    end
    vectors++;
    if (b_if.ready !== vb) begin
      miscompares++;
      $display("FAIL %s ready_b: got %b expected %b", tag, b_if.ready, vb);
    end
    vectors++;
    if (va && !oa) begin
      if (exp_qa.size() == 0) begin
        miscompares++;
        $display("FAIL %s rd_data_a: got %h expected nothing queued", tag, a_if.q);
      end else begin
        e = exp_qa.pop_front();
        last_a = e;
        if (a_if.q !== e) begin
          miscompares++;
          $display("FAIL %s rd_data_a: got %h expected %h", tag, a_if.q, e);
        end
      end
    end else if (a_if.q !== last_a) begin
      miscompares++;
      $display("FAIL %s rd_data_a hold: got %h expected %h", tag, a_if.q, last_a);
    end
    vectors++;
    if (vb && !ob) begin
      if (exp_qb.size() == 0) begin
        miscompares++;
        $display("FAIL %s rd_data_b: got %h expected nothing queued", tag, b_if.q);
      end else begin
        e = exp_qb.pop_front();
        last_b = e;
        if (b_if.q !== e) begin
          miscompares++;
          $display("FAIL %s rd_data_b: got %h expected %h", tag, b_if.q, e);
        end
      end
    end else if (b_if.q !== last_b) begin
      miscompares++;
      $display("FAIL %s rd_data_b hold: got %h expected %h", tag, b_if.q, last_b);
    end
    a_if.valid = 1'b0;
    b_if.valid = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (a_if.ready !== 1'b0 || b_if.ready !== 1'b0) begin
      miscompares++;
      $display("FAIL %s ready after resp: got a=%b b=%b expected 0 0", tag,
               a_if.ready, b_if.ready);
    end
  endtask

  task automatic test_reset();
    model_reset();
    #2;
    vectors++;
    if (a_if.ready !== 1'b0 || b_if.ready !== 1'b0 || state_a !== 1'b0 || state_b !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got ready %b%b state %b%b expected 00 00",
               a_if.ready, b_if.ready, state_a, state_b);
    end
    vectors++;
    if (a_if.q !== '0 || b_if.q !== '0) begin
      miscompares++;
      $display("FAIL reset_rd_data: got a=%h b=%h expected 0 0", a_if.q, b_if.q);
    end
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (a_if.ready !== 1'b0 || b_if.ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_hold_ready: got %b%b expected 00", a_if.ready, b_if.ready);
    end
    // Request is presented together with deassertion; first edge must take it.
    @(negedge clk);
    rstn = 1'b1;
    xact(1'b1, 1'b0, 8'h10, '0, 1'b1, 1'b0, 8'hFF, '0, "reset_read");
  endtask

  task automatic test_write_read();
    xact(1'b1, 1'b1, 8'h05, 32'hDEADBEEF, 1'b0, 1'b0, '0, '0, "wr_a_05");
    xact(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 8'h05, '0, "rd_b_05");
  endtask

  task automatic test_write_collision();
    xact(1'b1, 1'b1, 8'h22, 32'h1111_1111, 1'b1, 1'b1, 8'h22, 32'h2222_2222, "ww_22");
    xact(1'b1, 1'b0, 8'h22, '0, 1'b1, 1'b0, 8'h22, '0, "rr_22");
  endtask

  task automatic test_read_during_write();
    xact(1'b1, 1'b1, 8'h30, 32'h0000_0001, 1'b0, 1'b0, '0, '0, "wr_30_init");
    xact(1'b1, 1'b1, 8'h30, 32'hCAFE0000, 1'b1, 1'b0, 8'h30, '0, "rw_30");
    xact(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 8'h30, '0, "rd_30_after");
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] e;
    for (int i = 0; i < 4; i++) begin
      xact(1'b1, 1'b1, i[AW-1:0], $urandom, 1'b0, 1'b0, '0, '0, "b2b_fill");
    end
    a_if.valid = 1'b1; a_if.we = 1'b0; a_if.addr = 8'h00;
    for (int i = 0; i < 4; i++) begin
      exp_qa.push_back(model[i]);
      @(posedge clk); #1;
      vectors++;
      if (a_if.ready !== 1'b1 || state_a !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_resp[%0d]: got ready %b state %b expected 1 1", i, a_if.ready, state_a);
      end
      e = exp_qa.pop_front();
      last_a = e;
      vectors++;
      if (a_if.q !== e) begin
        miscompares++;
        $display("FAIL b2b_data[%0d]: got %h expected %h", i, a_if.q, e);
      end
      if (i < 3) a_if.addr = 8'(i + 1);
      else a_if.valid = 1'b0;
      @(posedge clk); #1;
      vectors++;
      if (a_if.ready !== 1'b0) begin
        miscompares++;
        $display("FAIL b2b_gap[%0d]: got ready %b expected 0", i, a_if.ready);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      xact(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'(8'h40 + $urandom_range(0, 3)),
           $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           8'(8'h40 + $urandom_range(0, 3)), $urandom, "random");
    end
  endtask

  task automatic test_reset_mid();
    xact(1'b1, 1'b1, 8'hFF, 32'h7, 1'b0, 1'b0, '0, '0, "mid_wr_ff");
    a_if.valid = 1'b1; a_if.we = 1'b1; a_if.addr = 8'hFF; a_if.data = 32'h9;
    b_if.valid = 1'b1; b_if.we = 1'b0; b_if.addr = 8'hFF;
    @(posedge clk); #1;
    vectors++;
    if (a_if.ready !== 1'b1 || b_if.ready !== 1'b1 || b_if.q !== 32'h7) begin
      miscompares++;
      $display("FAIL mid_accept: got ready %b%b q_b %h expected 11 00000007",
               a_if.ready, b_if.ready, b_if.q);
    end
    #2 rstn = 1'b0;
    #1;
    vectors++;
    if (a_if.ready !== 1'b0 || b_if.ready !== 1'b0 || b_if.q !== '0) begin
      miscompares++;
      $display("FAIL mid_async: got ready %b%b q_b %h expected 00 0", a_if.ready, b_if.ready, b_if.q);
    end
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (a_if.ready !== 1'b0 || b_if.ready !== 1'b0) begin
        miscompares++;
        $display("FAIL mid_hold[%0d]: got ready %b%b expected 00", i, a_if.ready, b_if.ready);
      end
    end
    a_if.valid = 1'b0;
    b_if.valid = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    xact(1'b1, 1'b0, 8'hFF, '0, 1'b1, 1'b0, 8'h05, '0, "mid_rd_ff");
  endtask

  initial begin
    a_if.valid = 1'b0; a_if.we = 1'b0; a_if.addr = '0; a_if.data = '0;
    b_if.valid = 1'b0; b_if.we = 1'b0; b_if.addr = '0; b_if.data = '0;
    test_reset();
    test_write_read();
    test_write_collision();
    test_read_during_write();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
